// File: rtl/qerv_state_seq_if.sv
// -----------------------------------------------------------------------------
// qerv_state_seq_if
//
// Bus handshake bundle of the phase sequencer.
//   o_ibus_cyc  instruction fetch request (driven by the sequencer)
//   i_ibus_ack  instruction fetch complete (driven by the bus)
//   o_dbus_cyc  data bus request (driven by the sequencer)
//   i_dbus_ack  data bus transfer complete (driven by the bus)
//
// Modports:
//   master : the sequencer side, which issues the cyc requests
//   slave  : the bus side, which answers with acks
// -----------------------------------------------------------------------------
interface qerv_state_seq_if;
    logic o_ibus_cyc;
    logic i_ibus_ack;
    logic o_dbus_cyc;
    logic i_dbus_ack;

    modport master (
        output o_ibus_cyc,
        output o_dbus_cyc,
        input  i_ibus_ack,
        input  i_dbus_ack
    );

    modport slave (
        input  o_ibus_cyc,
        input  o_dbus_cyc,
        output i_ibus_ack,
        output i_dbus_ack
    );
endinterface

// File: rtl/qerv_state_seq.sv
// -----------------------------------------------------------------------------
// qerv_state_seq
//
// Phase sequencer and bit counter for the W-bit-wide serial core. Fetches an
// instruction, then runs one or more 32-bit serial passes (INIT, RUN, TRAP),
// each 32/W cycles long, with a data-bus wait between INIT and RUN for memory
// operations.
//
// Parameters:
//   W              datapath chunk width (1 or 4)
//   RESET_STRATEGY "MINI" resets state and counter, "NONE" resets state only
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   bus              ibus/dbus cyc/ack handshakes (master side)
//   i_two_stage_op   instruction needs an INIT pass
//   i_mem_op         instruction is a load/store
//   i_e_op           instruction is ecall/ebreak
//   i_new_irq        pending timer interrupt
//   i_misalign       misaligned access/jump, sampled at end of INIT pass
//   o_en             serial pass active
//   o_init, o_trap   INIT / TRAP pass active
//   o_cnt            bit index of the chunk LSB
//   o_cnt0to3        chunk overlaps bits 0..3
//   o_cnt3, o_cnt7   bit 3 / bit 7 sits on the chunk MSB lane
//   o_cnt_done       last chunk of the pass
//
// Every output is decoded from registered state and counter only.
// -----------------------------------------------------------------------------
module qerv_state_seq #(
    parameter int W              = 1,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    qerv_state_seq_if.master     bus,
    input  logic                 i_two_stage_op,
    input  logic                 i_mem_op,
    input  logic                 i_e_op,
    input  logic                 i_new_irq,
    input  logic                 i_misalign,
    output logic                 o_en,
    output logic                 o_init,
    output logic                 o_trap,
    output logic [4:0]           o_cnt,
    output logic                 o_cnt0to3,
    output logic                 o_cnt3,
    output logic                 o_cnt7,
    output logic                 o_cnt_done
);

    // Counter step and the chunk positions that carry the strobes. Clearing
    // the low bits of 3 and 7 selects the chunk whose MSB lane holds that bit.
    localparam logic [4:0] CNT_STEP = 5'(W);
    localparam logic [4:0] CNT_LAST = 5'(32 - W);
    localparam logic [4:0] CNT_B3   = 5'(3 & ~(W - 1));
    localparam logic [4:0] CNT_B7   = 5'(7 & ~(W - 1));

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MEM_WAIT,
        RUN,
        TRAP
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [4:0] cnt_reg;
    logic [4:0] cnt_next;
    logic [4:0] cnt;
    logic       pass_active;
    logic       cnt_done;

    // A pass is active in INIT, RUN and TRAP; MEM_WAIT is a bubble.
    assign pass_active = (state_reg == INIT) || (state_reg == RUN) || (state_reg == TRAP);

    // The counter reads as zero whenever no pass runs. This also covers the
    // cycle after a mid-pass reset when the counter register is not reset.
    assign cnt      = pass_active ? cnt_reg : 5'd0;
    assign cnt_done = pass_active && (cnt == CNT_LAST);

    // Advances by W during a pass; the 5-bit add wraps 32-W back to 0 so that
    // back-to-back passes start at bit 0 without a bubble.
    assign cnt_next = pass_active ? (cnt + CNT_STEP) : 5'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    generate
        if (RESET_STRATEGY == "NONE") begin : g_cnt_noreset
            always_ff @(posedge i_clk) begin
                cnt_reg <= cnt_next;
            end
        end else begin : g_cnt_reset
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cnt_reg <= 5'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        bus.o_ibus_cyc = 1'b0;
        bus.o_dbus_cyc = 1'b0;
        o_en           = 1'b0;
        o_init         = 1'b0;
        o_trap         = 1'b0;

        case (state_reg)
            IDLE: begin
                bus.o_ibus_cyc = 1'b1;
                if (bus.i_ibus_ack) begin
                    // Interrupt and ecall/ebreak share one trap pass.
                    if (i_new_irq || i_e_op) begin
                        state_next = TRAP;
                    end else if (i_two_stage_op) begin
                        state_next = INIT;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            INIT: begin
                o_en   = 1'b1;
                o_init = 1'b1;
                if (cnt_done) begin
                    // A misaligned access traps before touching the data bus.
                    if (i_misalign) begin
                        state_next = TRAP;
                    end else if (i_mem_op) begin
                        state_next = MEM_WAIT;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                bus.o_dbus_cyc = 1'b1;
                if (bus.i_dbus_ack) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                o_en = 1'b1;
                if (cnt_done) begin
                    state_next = IDLE;
                end
            end
            TRAP: begin
                o_en   = 1'b1;
                o_trap = 1'b1;
                if (cnt_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_cnt      = cnt;
    assign o_cnt_done = cnt_done;
    assign o_cnt0to3  = pass_active && (cnt < 5'd4);
    assign o_cnt3     = pass_active && (cnt == CNT_B3);
    assign o_cnt7     = pass_active && (cnt == CNT_B7);

endmodule

// File: tb/tb_qerv_state_seq.sv
// -----------------------------------------------------------------------------
// tb_qerv_state_seq
//
// Drives three sequencers from shared stimulus: W=4/"MINI", W=4/"NONE" and
// W=1/"MINI". A vector table exercises the W=4 instances cycle by cycle; a
// hand-written sequence covers the 64-cycle W=1 two-stage instruction.
// -----------------------------------------------------------------------------
module tb_qerv_state_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ibus_ack, dbus_ack, two_stage, mem_op, e_op, new_irq, misalign;

    // Input bit positions in a vector's stimulus byte.
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_IACK = 8'h40;
    localparam logic [7:0] I_TWO  = 8'h20;
    localparam logic [7:0] I_MEM  = 8'h10;
    localparam logic [7:0] I_EOP  = 8'h08;
    localparam logic [7:0] I_IRQ  = 8'h04;
    localparam logic [7:0] I_MIS  = 8'h02;
    localparam logic [7:0] I_DACK = 8'h01;

    qerv_state_seq_if bus4 ();
    qerv_state_seq_if bus4n ();
    qerv_state_seq_if bus1 ();

    assign bus4.i_ibus_ack  = ibus_ack;
    assign bus4.i_dbus_ack  = dbus_ack;
    assign bus4n.i_ibus_ack = ibus_ack;
    assign bus4n.i_dbus_ack = dbus_ack;
    assign bus1.i_ibus_ack  = ibus_ack;
    assign bus1.i_dbus_ack  = dbus_ack;

    logic       en4, init4, trap4, c03_4, c3_4, c7_4, done4;
    logic [4:0] cnt4;
    logic       en4n, init4n, trap4n, c03_4n, c3_4n, c7_4n, done4n;
    logic [4:0] cnt4n;
    logic       en1, init1, trap1, c03_1, c3_1, c7_1, done1;
    logic [4:0] cnt1;

    qerv_state_seq #(.W(4), .RESET_STRATEGY("MINI")) u_w4 (
        .i_clk(clk), .i_rst(rst), .bus(bus4.master),
        .i_two_stage_op(two_stage), .i_mem_op(mem_op), .i_e_op(e_op),
        .i_new_irq(new_irq), .i_misalign(misalign),
        .o_en(en4), .o_init(init4), .o_trap(trap4), .o_cnt(cnt4),
        .o_cnt0to3(c03_4), .o_cnt3(c3_4), .o_cnt7(c7_4), .o_cnt_done(done4)
    );

    qerv_state_seq #(.W(4), .RESET_STRATEGY("NONE")) u_w4n (
        .i_clk(clk), .i_rst(rst), .bus(bus4n.master),
        .i_two_stage_op(two_stage), .i_mem_op(mem_op), .i_e_op(e_op),
        .i_new_irq(new_irq), .i_misalign(misalign),
        .o_en(en4n), .o_init(init4n), .o_trap(trap4n), .o_cnt(cnt4n),
        .o_cnt0to3(c03_4n), .o_cnt3(c3_4n), .o_cnt7(c7_4n), .o_cnt_done(done4n)
    );

    qerv_state_seq #(.W(1), .RESET_STRATEGY("MINI")) u_w1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1.master),
        .i_two_stage_op(two_stage), .i_mem_op(mem_op), .i_e_op(e_op),
        .i_new_irq(new_irq), .i_misalign(misalign),
        .o_en(en1), .o_init(init1), .o_trap(trap1), .o_cnt(cnt1),
        .o_cnt0to3(c03_1), .o_cnt3(c3_1), .o_cnt7(c7_1), .o_cnt_done(done1)
    );

    // Output word: {ibus_cyc, dbus_cyc, en, init, trap, cnt[4:0], cnt0to3, cnt3, cnt7, done}
    logic [13:0] act4, act4n, act1;
    assign act4  = {bus4.o_ibus_cyc, bus4.o_dbus_cyc, en4, init4, trap4, cnt4, c03_4, c3_4, c7_4, done4};
    assign act4n = {bus4n.o_ibus_cyc, bus4n.o_dbus_cyc, en4n, init4n, trap4n, cnt4n, c03_4n, c3_4n, c7_4n, done4n};
    assign act1  = {bus1.o_ibus_cyc, bus1.o_dbus_cyc, en1, init1, trap1, cnt1, c03_1, c3_1, c7_1, done1};

    typedef struct {
        string       name;
        logic [7:0]  stim;
        logic        chk;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] mk(input logic ib, input logic db, input logic en,
                                       input logic ini, input logic trp, input logic [4:0] c,
                                       input logic c03, input logic c3, input logic c7,
                                       input logic dn);
        return {ib, db, en, ini, trp, c, c03, c3, c7, dn};
    endfunction

    localparam logic [13:0] E_IDLE = 14'b10_000_00000_0000;
    localparam logic [13:0] E_WAIT = 14'b01_000_00000_0000;

    // W=4 pass, chunk k: cnt=4k; cnt0to3 and cnt3 only at chunk 0, cnt7 at
    // chunk 1 (bits 4..7), done at chunk 7 (bits 28..31).
    function automatic logic [13:0] e4(input int kind, input int k);
        return mk(1'b0, 1'b0, 1'b1, kind == 1, kind == 2, 5'(4 * k),
                  k == 0, k == 0, k == 1, k == 7);
    endfunction

    task automatic add(input string nm, input logic chk, input logic [13:0] e, input logic [7:0] s);
        vec_t v;
        v.name = nm;
        v.chk  = chk;
        v.exp  = e;
        v.stim = s;
        vecs.push_back(v);
    endtask

    // kind: 0 RUN, 1 INIT, 2 TRAP. last_in is driven on the done chunk,
    // extra_in on chunk extra_k.
    task automatic add_pass(input string nm, input int kind, input logic [7:0] last_in,
                            input int extra_k, input logic [7:0] extra_in);
        for (int k = 0; k < 8; k++) begin
            add($sformatf("%s_k%0d", nm, k), 1'b1, e4(kind, k),
                (k == 7 ? last_in : 8'h00) | (k == extra_k ? extra_in : 8'h00));
        end
    endtask

    task automatic drive(input logic [7:0] s);
        rst       = s[7];
        ibus_ack  = s[6];
        two_stage = s[5];
        mem_op    = s[4];
        e_op      = s[3];
        new_irq   = s[2];
        misalign  = s[1];
        dbus_ack  = s[0];
    endtask

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b (ibus dbus en init trap cnt c03 c3 c7 done)", nm, act, exp);
        end
    endtask

    initial begin
        drive(8'h00);

        // Plain ALU op: one 8-cycle RUN pass, then fetch again.
        add("alu_rst", 1'b0, E_IDLE, I_RST);
        add("alu_reset_state", 1'b1, E_IDLE, I_IACK);
        add_pass("alu_run", 0, 8'h00, -1, 8'h00);
        add("alu_refetch", 1'b1, E_IDLE, 8'h00);

        // Load: INIT, 5-cycle dbus wait, RUN. Stray acks in INIT/RUN ignored.
        add("ld_rst", 1'b0, E_IDLE, I_RST);
        add("ld_fetch", 1'b1, E_IDLE, I_IACK | I_TWO | I_MEM);
        add_pass("ld_init", 1, I_MEM, 1, I_DACK);
        for (int i = 0; i < 5; i++) begin
            add($sformatf("ld_wait%0d", i), 1'b1, E_WAIT, (i == 4) ? I_DACK : 8'h00);
        end
        add_pass("ld_run", 0, 8'h00, 2, I_DACK | I_IACK);
        add("ld_refetch", 1'b1, E_IDLE, 8'h00);

        // Interrupt and ecall together: a single TRAP pass.
        add("trap_rst", 1'b0, E_IDLE, I_RST);
        add("trap_fetch", 1'b1, E_IDLE, I_IACK | I_IRQ | I_EOP | I_TWO | I_MEM);
        add_pass("trap_pass", 2, 8'h00, -1, 8'h00);
        add("trap_idle0", 1'b1, E_IDLE, 8'h00);
        add("trap_idle1", 1'b1, E_IDLE, 8'h00);

        // Misaligned mem op: straight from INIT into TRAP, no dbus request.
        add("mis_fetch", 1'b1, E_IDLE, I_IACK | I_TWO | I_MEM);
        add_pass("mis_init", 1, I_MIS | I_MEM, -1, 8'h00);
        add_pass("mis_trap", 2, 8'h00, -1, 8'h00);
        add("mis_idle", 1'b1, E_IDLE, 8'h00);

        // Two-stage non-mem op at W=4: INIT flows directly into RUN.
        add("two_fetch", 1'b1, E_IDLE, I_IACK | I_TWO);
        add_pass("two_init", 1, 8'h00, -1, 8'h00);
        add_pass("two_run", 0, 8'h00, -1, 8'h00);
        add("two_idle", 1'b1, E_IDLE, 8'h00);

        // Reset at cnt 12 of RUN with a simultaneous ibus ack.
        add("rstmid_fetch", 1'b1, E_IDLE, I_IACK);
        for (int k = 0; k < 4; k++) begin
            add($sformatf("rstmid_run_k%0d", k), 1'b1, e4(0, k), (k == 3) ? (I_RST | I_IACK) : 8'h00);
        end
        add("rstmid_after", 1'b1, E_IDLE, 8'h00);
        add("rstmid_still_idle", 1'b1, E_IDLE, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                check(vecs[i].name, act4, vecs[i].exp);
                check({vecs[i].name, "_none"}, act4n, vecs[i].exp);
            end
            drive(vecs[i].stim);
        end

        // W=1 two-stage non-mem op: 64 back-to-back o_en cycles.
        @(negedge clk);
        drive(I_RST);
        @(negedge clk);
        check("w1_reset_state", act1, E_IDLE);
        drive(I_IACK | I_TWO);
        for (int i = 0; i < 64; i++) begin
            logic [4:0] c;
            @(negedge clk);
            drive(8'h00);
            c = 5'(i % 32);
            check($sformatf("w1_cycle%0d", i), act1,
                  mk(1'b0, 1'b0, 1'b1, i < 32, 1'b0, c, c < 5'd4, c == 5'd3, c == 5'd7, c == 5'd31));
        end
        @(negedge clk);
        check("w1_refetch", act1, E_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
